mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Arbitrates between NUM_REQ requesters (I-cache miss, D-cache miss, write-back, prefetch) for the single shared memory port of the mips_core.
- Picks a winner using a rotating priority-encoder search, or a fixed lowest-index-first search.
- Holds the grant until the memory side signals completion or a watchdog timeout expires.
- Sits between the cache miss handlers and the memory interface adapter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16, need not be a power of 2.
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.
- TIMEOUT, 255, maximum BUSY cycles without mem_done before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request lines, one per requester; level-sensitive.
- mem_done  in  1  one-cycle pulse from memory: the granted transaction is complete.
- grant  out  NUM_REQ  one-hot grant, registered; all zero when idle.
- grant_valid  out  1  high while any grant is held (OR of grant).
- grant_id  out  $clog2(NUM_REQ)  binary index of the granted requester; 0 when idle.
- mem_start  out  1  one-cycle pulse in the first cycle of each new grant.
- timeout_err  out  1  one-cycle pulse in the cycle a grant is force-released.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, grant_valid=0, grant_id=0, mem_start=0, timeout_err=0, rr_ptr=0, watchdog count=0. Takes effect immediately, including mid-transaction; no mem_start and no timeout_err are issued on reset release.
- States: IDLE and BUSY.
- IDLE:
  - If any req bit is high at a clock edge, go to BUSY with the winner registered; grant, grant_id and mem_start are valid in the next cycle (1-cycle latency).
  - mem_done is ignored in IDLE.
- Winner search, ROUND_ROBIN=1: scan indices rr_ptr, rr_ptr+1, ..., wrapping from NUM_REQ-1 to 0; the first set bit wins. On each grant to k, rr_ptr := (k+1) mod NUM_REQ.
- Winner search, ROUND_ROBIN=0: lowest set index wins; rr_ptr stays 0.
- BUSY:
  - grant is held stable.
  - If the granted requester drops req, this is ignored; the grant persists until release.
  - Release occurs on mem_done, or on a watchdog expiry.
- Release with other requests pending (back-to-back):
  - Arbitrate the same cycle over req with the current holder's bit masked.
  - If any masked bit is set, stay in BUSY. The new grant and a new mem_start appear in the next cycle, with no idle bubble.
  - Otherwise go to IDLE; grant is 0 in the next cycle.
- Watchdog:
  - Count clears when a grant is issued and increments on each BUSY cycle without mem_done.
  - In a BUSY cycle where count==TIMEOUT-1 and mem_done=0, release as above and pulse timeout_err in the following cycle, aligned with the grant drop or re-grant.
  - The grant is therefore held exactly TIMEOUT cycles.
  - mem_done in the expiry cycle wins: normal release, no timeout_err.
  - TIMEOUT=0 disables the watchdog; the counter is held at 0.
- rr_ptr advances on every grant, including grants that later time out.
- Invariants:
  - grant is always zero or one-hot.
  - grant_id is consistent with grant.
  - mem_start is high only in the first cycle of a grant.

Test Plan:
1. Reset: drive rst_n low mid-BUSY with grant=0100 -> grant, grant_id, mem_start and timeout_err go to 0 without waiting for a clock edge. After release, req=0001 -> grant=0001 one cycle later (rr_ptr was reset to 0).
2. Single request: req=0100 from cycle 0 -> cycle 1: grant=0100, grant_id=2, mem_start=1; cycle 2: mem_start=0. mem_done at cycle 5 with req dropped -> cycle 6: grant=0000, grant_valid=0.
3. Round robin: req=1111 held, mem_done pulsed every 3rd cycle -> grant_id sequence 0,1,2,3,0 with no idle cycles between grants, and one mem_start per grant.
4. Fixed priority (ROUND_ROBIN=0): req=1010 held -> grant_id alternates 1,3,1,3 because the holder is masked at release. With req=0010 alone -> grant goes to 0 after mem_done.
5. Watchdog (TIMEOUT=8), req=0001 then dropped, no mem_done -> grant held cycles 1..8; cycle 9: grant=0, timeout_err=1 for exactly one cycle. Repeat with mem_done in the 8th BUSY cycle -> no timeout_err.
6. Non-power-of-2 (NUM_REQ=3): req=111 held, rr_ptr=2 at start -> grant order 2,0,1,2; grant_id never exceeds 2.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// rtl/mem_request_arbiter_if.sv - request/grant bundle between miss handlers and the memory port arbiter
interface mem_request_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               mem_done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               mem_start;
  logic               timeout_err;

  // Requesters and the memory adapter drive req/mem_done; the arbiter answers.
  modport master (
    output req, mem_done,
    input  grant, grant_valid, grant_id, mem_start, timeout_err
  );
  modport slave (
    input  req, mem_done,
    output grant, grant_valid, grant_id, mem_start, timeout_err
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - rotating/fixed priority arbiter for the shared memory port with watchdog
module mem_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_request_arbiter_if.slave  bus_if
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    grant_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic               mem_start_q;
  logic               timeout_err_q;
  logic [WD_W-1:0]    wd_cnt_q;

  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    win_next;
  logic               wd_expire;
  logic               release_now;
  logic               take;

  function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    // Holder is masked so a release re-arbitrates among the others only.
    cand      = bus_if.req & ~grant_q;
    win_found = 1'b0;
    win_id    = '0;
    // Descending scan: the last hit is the first index in rotation order.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[slot(rr_ptr_q, i)]) begin
        win_found = 1'b1;
        win_id    = slot(rr_ptr_q, i);
      end
    end
    win_next    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    wd_expire   = (TIMEOUT != 0) && (state_q == BUSY) && !bus_if.mem_done &&
                  (wd_cnt_q == WD_W'(TIMEOUT - 1));
    release_now = (state_q == BUSY) && (bus_if.mem_done || wd_expire);
    take        = win_found && ((state_q == IDLE) || release_now);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      mem_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      mem_start_q   <= take;
      timeout_err_q <= wd_expire;
      if (take) begin
        state_q    <= BUSY;
        grant_q    <= NUM_REQ'(1) << win_id;
        grant_id_q <= win_id;
        wd_cnt_q   <= '0;
        rr_ptr_q   <= ROUND_ROBIN ? win_next : '0;
      end else if (release_now) begin
        state_q    <= IDLE;
        grant_q    <= '0;
        grant_id_q <= '0;
        wd_cnt_q   <= '0;
      end else if ((state_q == BUSY) && (TIMEOUT != 0)) begin
        wd_cnt_q   <= wd_cnt_q + 1'b1;
      end
    end
  end

  assign bus_if.grant       = grant_q;
  assign bus_if.grant_valid = |grant_q;
  assign bus_if.grant_id    = grant_id_q;
  assign bus_if.mem_start   = mem_start_q;
  assign bus_if.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb/tb_mem_request_arbiter.sv - self-checking bench for mem_request_arbiter
module tb_mem_request_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_request_arbiter_if #(.NUM_REQ(4)) ia ();
  mem_request_arbiter_if #(.NUM_REQ(4)) ib ();
  mem_request_arbiter_if #(.NUM_REQ(3)) ic ();

  mem_request_arbiter #(.NUM_REQ(4), .ROUND_ROBIN(1'b1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus_if(ia.slave));
  mem_request_arbiter #(.NUM_REQ(4), .ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_if(ib.slave));
  mem_request_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1'b1), .TIMEOUT(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus_if(ic.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: who holds the port, how many busy cycles have elapsed, and where the rotation starts.
  typedef struct {
    bit busy;
    int id;
    int ptr;
    int cnt;
    bit start;
    bit terr;
  } mstate_t;

  mstate_t m[3];

  function automatic mstate_t idle_state();
    mstate_t r;
    r.busy = 0; r.id = 0; r.ptr = 0; r.cnt = 0; r.start = 0; r.terr = 0;
    return r;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [3:0] req, input logic done,
                                   input int n, input bit rr, input int to);
    mstate_t    r;
    logic [3:0] pend;
    bit         expired;
    int         k;
    r = s; r.start = 0; r.terr = 0;
    pend = req;
    if (s.busy) begin
      expired = (to != 0) && !done && (s.cnt + 1 == to);
      if (!done && !expired) begin
        r.cnt = s.cnt + 1;
        return r;
      end
      r.terr = expired;
      pend[s.id] = 1'b0;
      r.busy = 0; r.id = 0; r.cnt = 0;
    end
    for (int j = 0; j < n; j++) begin
      k = ((rr ? s.ptr : 0) + j) % n;
      if (pend[k]) begin
        r.busy = 1; r.id = k; r.start = 1; r.cnt = 0;
        r.ptr = rr ? (k + 1) % n : 0;
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= idle_state();
    end else begin
      m[0] <= step(m[0], ia.req, ia.mem_done, 4, 1'b1, 8);
      m[1] <= step(m[1], ib.req, ib.mem_done, 4, 1'b0, 0);
      m[2] <= step(m[2], {1'b0, ic.req}, ic.mem_done, 3, 1'b1, 4);
    end
  end

  task automatic cmp(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v,
                     input logic s, input logic t, input mstate_t e);
    check({tag, "_grant"}, {28'd0, g}, e.busy ? (32'd1 << e.id) : 32'd0);
    check({tag, "_grant_id"}, {30'd0, id}, e.busy ? e.id : 0);
    check({tag, "_grant_valid"}, {31'd0, v}, {31'd0, e.busy});
    check({tag, "_mem_start"}, {31'd0, s}, {31'd0, e.start});
    check({tag, "_timeout_err"}, {31'd0, t}, {31'd0, e.terr});
  endtask

  always @(negedge clk) begin
    cmp("a", ia.grant, ia.grant_id, ia.grant_valid, ia.mem_start, ia.timeout_err, m[0]);
    cmp("b", ib.grant, ib.grant_id, ib.grant_valid, ib.mem_start, ib.timeout_err, m[1]);
    cmp("c", {1'b0, ic.grant}, ic.grant_id, ic.grant_valid, ic.mem_start, ic.timeout_err, m[2]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int ids[$];
  int exp3[5] = '{0, 1, 2, 3, 0};
  int exp4[4] = '{1, 3, 1, 3};
  int exp6[4] = '{2, 0, 1, 2};

  initial begin
    ia.req = '0; ia.mem_done = 1'b0;
    ib.req = '0; ib.mem_done = 1'b0;
    ic.req = '0; ic.mem_done = 1'b0;
    repeat (2) tick();
    check("reset_grant", {28'd0, ia.grant}, 32'd0);
    check("reset_mem_start", {31'd0, ia.mem_start}, 32'd0);
    rst_n = 1'b1;

    // single request, 1-cycle latency, done at cycle 5
    ia.req = 4'b0100;
    tick();
    check("t2_grant", {28'd0, ia.grant}, 32'h4);
    check("t2_grant_id", {30'd0, ia.grant_id}, 32'd2);
    check("t2_mem_start", {31'd0, ia.mem_start}, 32'd1);
    tick();
    check("t2_mem_start_low", {31'd0, ia.mem_start}, 32'd0);
    ia.req = '0;
    repeat (3) tick();
    ia.mem_done = 1'b1;
    tick();
    ia.mem_done = 1'b0;
    check("t2_release_grant", {28'd0, ia.grant}, 32'd0);
    check("t2_release_valid", {31'd0, ia.grant_valid}, 32'd0);

    // asynchronous reset mid-transaction
    ia.req = 4'b0100;
    tick();
    check("t1_busy_grant", {28'd0, ia.grant}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_grant", {28'd0, ia.grant}, 32'd0);
    check("t1_async_id", {30'd0, ia.grant_id}, 32'd0);
    check("t1_async_start", {31'd0, ia.mem_start}, 32'd0);
    check("t1_async_terr", {31'd0, ia.timeout_err}, 32'd0);
    ia.req = 4'b1001;
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_ptr_reset_grant", {28'd0, ia.grant}, 32'h1);
    ia.req = '0; ia.mem_done = 1'b1;
    tick();
    ia.mem_done = 1'b0;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // round robin, done every 3rd cycle
    ids = {};
    ia.req = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (ia.mem_start) ids.push_back(int'(ia.grant_id));
      ia.mem_done = (c % 3 == 0);
      if (c == 15) ia.req = '0;
    end
    tick();
    ia.mem_done = 1'b0;
    check("t3_grant_count", ids.size(), 32'd5);
    for (int i = 0; i < 5 && i < ids.size(); i++) check("t3_order", ids[i], exp3[i]);

    // watchdog expiry after exactly 8 busy cycles
    ia.req = 4'b0001;
    tick();
    ia.req = '0;
    repeat (7) tick();
    check("t5_held_c8", {28'd0, ia.grant}, 32'h1);
    check("t5_no_terr_c8", {31'd0, ia.timeout_err}, 32'd0);
    tick();
    check("t5_drop_c9", {28'd0, ia.grant}, 32'd0);
    check("t5_terr_c9", {31'd0, ia.timeout_err}, 32'd1);
    tick();
    check("t5_terr_c10", {31'd0, ia.timeout_err}, 32'd0);

    // mem_done in the expiry cycle wins
    ia.req = 4'b0001;
    tick();
    ia.req = '0;
    repeat (7) tick();
    ia.mem_done = 1'b1;
    tick();
    ia.mem_done = 1'b0;
    check("t5b_drop", {28'd0, ia.grant}, 32'd0);
    check("t5b_no_terr", {31'd0, ia.timeout_err}, 32'd0);

    // back-to-back timeouts with another requester waiting
    ia.req = 4'b0011;
    repeat (20) tick();
    ia.req = '0;
    repeat (10) tick();

    // fixed priority, holder masked at release
    ids = {};
    ib.req = 4'b1010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ib.mem_start) ids.push_back(int'(ib.grant_id));
      ib.mem_done = (c % 2 == 0);
      if (c == 8) ib.req = '0;
    end
    tick();
    ib.mem_done = 1'b0;
    check("t4_grant_count", ids.size(), 32'd4);
    for (int i = 0; i < 4 && i < ids.size(); i++) check("t4_order", ids[i], exp4[i]);
    ib.req = 4'b0010;
    tick();
    ib.mem_done = 1'b1;
    tick();
    ib.mem_done = 1'b0;
    check("t4_solo_release", {28'd0, ib.grant}, 32'd0);
    ib.req = '0;
    repeat (2) tick();

    // disabled watchdog never releases
    ib.req = 4'b0100;
    repeat (20) tick();
    check("t4_wd_off_held", {28'd0, ib.grant}, 32'h4);
    check("t4_wd_off_terr", {31'd0, ib.timeout_err}, 32'd0);
    ib.req = '0; ib.mem_done = 1'b1;
    tick();
    ib.mem_done = 1'b0;

    // NUM_REQ=3 wraparound starting from rr_ptr=2
    ic.req = 3'b010;
    tick();
    ic.req = '0; ic.mem_done = 1'b1;
    tick();
    ic.mem_done = 1'b0;
    ids = {};
    ic.req = 3'b111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ic.mem_start) ids.push_back(int'(ic.grant_id));
      ic.mem_done = (c % 2 == 0);
      if (c == 8) ic.req = '0;
    end
    tick();
    ic.mem_done = 1'b0;
    check("t6_grant_count", ids.size(), 32'd4);
    for (int i = 0; i < 4 && i < ids.size(); i++) check("t6_order", ids[i], exp6[i]);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
